// File: rtl/usb_fs_out_buf_ctrl_pkg.sv
// Shared types and constants for the full-speed OUT buffer controller.
// Buffer geometry lives here because the receive record layout depends on it.
package usb_out_ctrl_pkg;

    localparam int unsigned NumBufs           = 8;
    localparam int unsigned MaxOutPktSizeByte = 32;
    localparam int unsigned PktW              = $clog2(MaxOutPktSizeByte);
    localparam int unsigned BufIdW            = $clog2(NumBufs);
    localparam int unsigned CrcBytes          = 2;

    typedef enum logic {
        StIdle = 1'b0,
        StRcv  = 1'b1
    } state_e;

    typedef struct packed {
        logic [BufIdW-1:0] buf_id;
        logic [3:0]        ep;
        logic              setup;
        logic [PktW:0]     size;
    } rx_rec_t;

    localparam int unsigned RecW = $bits(rx_rec_t);

    // Received byte count minus the trailing CRC16, floored at zero.
    function automatic logic [PktW:0] payload_size(input logic [PktW+1:0] cnt);
        if (cnt >= (PktW + 2)'(CrcBytes)) begin
            return (PktW + 1)'(cnt - (PktW + 2)'(CrcBytes));
        end
        return '0;
    endfunction

endpackage

// File: rtl/usb_fs_out_buf_ctrl_if.sv
// Software-side register interface: free-buffer push and completion-record pop.
interface usb_fs_out_buf_ctrl_if
    import usb_out_ctrl_pkg::*;
#(
    parameter int unsigned RxDepthW = 3
);
    logic                av_push_i;
    logic [BufIdW-1:0]   av_buf_i;
    logic                av_full_o;
    logic                av_overflow_o;
    logic                rx_pop_i;
    logic                rx_valid_o;
    logic [BufIdW-1:0]   rx_buf_o;
    logic [3:0]          rx_ep_o;
    logic                rx_setup_o;
    logic [PktW:0]       rx_size_o;
    logic [RxDepthW-1:0] rx_depth_o;

    modport master (
        output av_push_i, av_buf_i, rx_pop_i,
        input  av_full_o, av_overflow_o, rx_valid_o, rx_buf_o, rx_ep_o,
               rx_setup_o, rx_size_o, rx_depth_o
    );

    modport slave (
        input  av_push_i, av_buf_i, rx_pop_i,
        output av_full_o, av_overflow_o, rx_valid_o, rx_buf_o, rx_ep_o,
               rx_setup_o, rx_size_o, rx_depth_o
    );
endinterface

// File: rtl/usb_fs_out_buf_ctrl_sync_fifo.sv
// Registered synchronous FIFO with occupancy output; reads zero when empty.
module usb_fs_sync_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 4,
    localparam int unsigned DepthW = $clog2(Depth + 1)
) (
    input  logic              clk_48mhz_i,
    input  logic              rst_i,
    input  logic              push,
    input  logic [Width-1:0]  wdata,
    input  logic              pop,
    output logic [Width-1:0]  rdata,
    output logic [DepthW-1:0] depth
);
    localparam int unsigned    PtrW    = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);

    logic [Width-1:0]  mem_q [Depth];
    logic [PtrW-1:0]   rptr_q;
    logic [PtrW-1:0]   wptr_q;
    logic [DepthW-1:0] cnt_q;
    logic              empty;
    logic              full;
    logic              do_push;
    logic              do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == DepthW'(Depth));
    assign do_pop  = pop & ~empty;
    // A pop frees the slot in the same cycle, so push into a full FIFO is kept then.
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk_48mhz_i) begin
        if (rst_i) begin
            rptr_q <= '0;
            wptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wptr_q <= (wptr_q == LastPtr) ? '0 : wptr_q + PtrW'(1);
            if (do_pop)  rptr_q <= (rptr_q == LastPtr) ? '0 : rptr_q + PtrW'(1);
            cnt_q <= cnt_q + DepthW'(do_push) - DepthW'(do_pop);
        end
    end

    always_ff @(posedge clk_48mhz_i) begin
        if (do_push) mem_q[wptr_q] <= wdata;
    end

    assign rdata = empty ? '0 : mem_q[rptr_q];
    assign depth = cnt_q;

endmodule

// File: rtl/usb_fs_out_buf_ctrl.sv
// OUT buffer/receive-queue controller between the FS packet engine and packet SRAM.
// Optional build macro USB_OUT_SETUP_RSV_EN reserves one receive slot for SETUP.
module usb_fs_out_buf_ctrl
    import usb_out_ctrl_pkg::*;
#(
    parameter int unsigned NumOutEps = 4,
    parameter int unsigned AvDepth   = 4,
    parameter int unsigned RxDepth   = 4
) (
    input  logic                    clk_48mhz_i,
    input  logic                    rst_i,
    input  logic                    link_reset_i,
    input  logic [NumOutEps-1:0]    rx_enable_i,
    input  logic [3:0]              out_ep_current_i,
    input  logic                    out_ep_newpkt_i,
    input  logic                    out_ep_data_put_i,
    input  logic [PktW-1:0]         out_ep_put_addr_i,
    input  logic [7:0]              out_ep_data_i,
    input  logic                    out_ep_acked_i,
    input  logic                    out_ep_rollback_i,
    input  logic [NumOutEps-1:0]    out_ep_setup_i,
    output logic [NumOutEps-1:0]    out_ep_full_o,
    output logic                    buf_we_o,
    output logic [BufIdW+PktW-1:0]  buf_waddr_o,
    output logic [7:0]              buf_wdata_o,
    usb_fs_out_buf_ctrl_if.slave    sw
);
    localparam int unsigned CntW     = PktW + 2;
    localparam int unsigned AvDepthW = $clog2(AvDepth + 1);
    localparam int unsigned RxDepthW = $clog2(RxDepth + 1);
    localparam int unsigned EpIdxW   = (NumOutEps > 1) ? $clog2(NumOutEps) : 1;
    localparam logic [CntW-1:0] CntSat = CntW'(MaxOutPktSizeByte + CrcBytes);
    localparam logic [CntW-1:0] CntMax = CntW'(MaxOutPktSizeByte);

    state_e              state_q;
    logic                have_buf_q;
    logic [BufIdW-1:0]   cur_buf_q;
    logic [CntW-1:0]     byte_cnt_q;
    logic                av_overflow_q;

    logic [BufIdW-1:0]   av_head;
    logic [AvDepthW-1:0] av_depth;
    logic                av_full;
    logic                av_pop;
    rx_rec_t             rx_rec;
    rx_rec_t             rx_head;
    logic [RxDepthW-1:0] rx_depth;
    logic                rx_push;
    logic                rx_at_cap;
    logic                ep_in_range;
    logic                setup_cur;
    logic                cnt_inc;

    assign av_full     = (av_depth == AvDepthW'(AvDepth));
    assign av_pop      = (state_q == StIdle) & ~have_buf_q & (av_depth != '0);
    assign rx_at_cap   = (rx_depth == RxDepthW'(RxDepth));
    assign ep_in_range = ({1'b0, out_ep_current_i} < 5'(NumOutEps));
    assign setup_cur   = ep_in_range & out_ep_setup_i[EpIdxW'(out_ep_current_i)];
    assign cnt_inc     = out_ep_data_put_i & have_buf_q & (byte_cnt_q != CntSat);

    // Completion is only queued for a live packet that owns a buffer.
    assign rx_push = (state_q == StRcv) & out_ep_acked_i & ~out_ep_rollback_i
                   & have_buf_q & ~link_reset_i;

    always_comb begin
        rx_rec        = '0;
        rx_rec.buf_id = cur_buf_q;
        rx_rec.ep     = out_ep_current_i;
        rx_rec.setup  = setup_cur;
        rx_rec.size   = payload_size(byte_cnt_q);
    end

    usb_fs_sync_fifo #(
        .Width (BufIdW),
        .Depth (AvDepth)
    ) u_av_fifo (
        .clk_48mhz_i (clk_48mhz_i),
        .rst_i       (rst_i),
        .push        (sw.av_push_i),
        .wdata       (sw.av_buf_i),
        .pop         (av_pop),
        .rdata       (av_head),
        .depth       (av_depth)
    );

    usb_fs_sync_fifo #(
        .Width (RecW),
        .Depth (RxDepth)
    ) u_rx_fifo (
        .clk_48mhz_i (clk_48mhz_i),
        .rst_i       (rst_i),
        .push        (rx_push),
        .wdata       (rx_rec),
        .pop         (sw.rx_pop_i),
        .rdata       (rx_head),
        .depth       (rx_depth)
    );

`ifdef USB_OUT_SETUP_RSV_EN
    logic rx_at_rsv;
    assign rx_at_rsv = (rx_depth >= RxDepthW'(RxDepth - 1));

    // SETUP bypasses the enable and may use the last slot; everything else stops one early.
    always_comb begin
        out_ep_full_o = '1;
        for (int e = 0; e < NumOutEps; e++) begin
            if (setup_cur && (4'(e) == out_ep_current_i)) begin
                out_ep_full_o[e] = ~have_buf_q | rx_at_cap;
            end else begin
                out_ep_full_o[e] = ~have_buf_q | ~rx_enable_i[e] | rx_at_rsv;
            end
        end
    end
`else
    always_comb begin
        out_ep_full_o = '1;
        for (int e = 0; e < NumOutEps; e++) begin
            out_ep_full_o[e] = ~have_buf_q | ~rx_enable_i[e] | rx_at_cap;
        end
    end
`endif

    assign buf_we_o    = out_ep_data_put_i & (state_q == StRcv) & have_buf_q
                       & (byte_cnt_q < CntMax);
    assign buf_waddr_o = {cur_buf_q, out_ep_put_addr_i};
    assign buf_wdata_o = out_ep_data_i;

    // Receive FSM, buffer ownership and byte counter.
    always_ff @(posedge clk_48mhz_i) begin
        if (rst_i) begin
            state_q       <= StIdle;
            have_buf_q    <= 1'b0;
            cur_buf_q     <= '0;
            byte_cnt_q    <= '0;
            av_overflow_q <= 1'b0;
        end else begin
            av_overflow_q <= sw.av_push_i & av_full & ~av_pop;
            if (av_pop) begin
                have_buf_q <= 1'b1;
                cur_buf_q  <= av_head;
            end
            if (link_reset_i) begin
                state_q    <= StIdle;
                byte_cnt_q <= '0;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (out_ep_newpkt_i) begin
                            state_q    <= StRcv;
                            byte_cnt_q <= '0;
                        end
                    end
                    StRcv: begin
                        if (out_ep_rollback_i) begin
                            state_q    <= StIdle;
                            byte_cnt_q <= '0;
                        end else if (out_ep_acked_i) begin
                            state_q    <= StIdle;
                            have_buf_q <= 1'b0;
                            byte_cnt_q <= '0;
                        end else if (out_ep_newpkt_i) begin
                            byte_cnt_q <= '0;
                        end else if (cnt_inc) begin
                            byte_cnt_q <= byte_cnt_q + CntW'(1);
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign sw.av_full_o     = av_full;
    assign sw.av_overflow_o = av_overflow_q;
    assign sw.rx_valid_o    = (rx_depth != '0);
    assign sw.rx_buf_o      = rx_head.buf_id;
    assign sw.rx_ep_o       = rx_head.ep;
    assign sw.rx_setup_o    = rx_head.setup;
    assign sw.rx_size_o     = rx_head.size;
    assign sw.rx_depth_o    = rx_depth;

endmodule

// File: tb/tb_usb_fs_out_buf_ctrl.sv
// Randomized bench for usb_fs_out_buf_ctrl against a queue-based reference model.
module tb_usb_fs_out_buf_ctrl;
    import usb_out_ctrl_pkg::*;

    localparam int NEps = 4;
    localparam int AvD  = 4;
    localparam int RxD  = 4;
    localparam int MaxB = 32;

    logic       clk = 1'b0;
    logic       rst, link_reset, newpkt, put, acked, rollback;
    logic [3:0] rx_enable, current, setup, full;
    logic [4:0] addr;
    logic [7:0] data, wdata, waddr;
    logic       we;

    always #10 clk = ~clk;

    usb_fs_out_buf_ctrl_if sw_if ();

    usb_fs_out_buf_ctrl dut (
        .clk_48mhz_i       (clk),
        .rst_i             (rst),
        .link_reset_i      (link_reset),
        .rx_enable_i       (rx_enable),
        .out_ep_current_i  (current),
        .out_ep_newpkt_i   (newpkt),
        .out_ep_data_put_i (put),
        .out_ep_put_addr_i (addr),
        .out_ep_data_i     (data),
        .out_ep_acked_i    (acked),
        .out_ep_rollback_i (rollback),
        .out_ep_setup_i    (setup),
        .out_ep_full_o     (full),
        .buf_we_o          (we),
        .buf_waddr_o       (waddr),
        .buf_wdata_o       (wdata),
        .sw                (sw_if)
    );

    typedef struct {int b; int ep; int s; int sz;} rec_t;
    int   av_q[$];
    rec_t rx_q[$];
    bit   m_have, m_rcv, m_ovf;
    int   m_buf, m_cnt;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit cur_setup();
        int c = int'(current);
        return (c < NEps) && (((setup >> c) & 4'd1) != 4'd0);
    endfunction

    function automatic logic [3:0] exp_full();
        logic [3:0] f;
        int d = rx_q.size();
        for (int e = 0; e < NEps; e++) begin
            bit en = ((rx_enable >> e) & 4'd1) != 4'd0;
`ifdef USB_OUT_SETUP_RSV_EN
            if (cur_setup() && int'(current) == e) f[e] = !m_have || d == RxD;
            else f[e] = !m_have || !en || d >= RxD - 1;
`else
            f[e] = !m_have || !en || d == RxD;
`endif
        end
        return f;
    endfunction

    task automatic check_outputs();
        bit exp_we = put && m_rcv && m_have && m_cnt < MaxB;
        check("full", full, exp_full());
        check("buf_we", we, exp_we);
        if (exp_we) begin
            check("waddr", waddr, m_buf * MaxB + int'(addr));
            check("wdata", wdata, data);
        end
        check("av_full", sw_if.av_full_o, av_q.size() == AvD);
        check("av_ovf", sw_if.av_overflow_o, m_ovf);
        check("rx_depth", sw_if.rx_depth_o, rx_q.size());
        check("rx_valid", sw_if.rx_valid_o, rx_q.size() != 0);
        check("rx_buf", sw_if.rx_buf_o, rx_q.size() ? rx_q[0].b : 0);
        check("rx_ep", sw_if.rx_ep_o, rx_q.size() ? rx_q[0].ep : 0);
        check("rx_setup", sw_if.rx_setup_o, rx_q.size() ? rx_q[0].s : 0);
        check("rx_size", sw_if.rx_size_o, rx_q.size() ? rx_q[0].sz : 0);
    endtask

    // Advances the model by one clock using the inputs held across the edge.
    task automatic model_step();
        bit   pop_av, av_acc, do_rx, rx_acc;
        rec_t r;
        if (rst) begin
            av_q.delete(); rx_q.delete();
            m_have = 0; m_rcv = 0; m_cnt = 0; m_ovf = 0; m_buf = 0;
            return;
        end
        pop_av = !m_rcv && !m_have && av_q.size() > 0;
        av_acc = sw_if.av_push_i && (av_q.size() < AvD || pop_av);
        m_ovf  = sw_if.av_push_i && !av_acc;
        do_rx  = !link_reset && m_rcv && acked && !rollback && m_have;
        rx_acc = do_rx && (rx_q.size() < RxD || (sw_if.rx_pop_i && rx_q.size() > 0));
        r = '{b: m_buf, ep: int'(current), s: int'(cur_setup()), sz: (m_cnt >= 2) ? m_cnt - 2 : 0};
        if (sw_if.rx_pop_i && rx_q.size() > 0) void'(rx_q.pop_front());
        if (rx_acc) rx_q.push_back(r);
        if (pop_av) begin m_buf = av_q.pop_front(); m_have = 1; end
        if (av_acc) av_q.push_back(int'(sw_if.av_buf_i));
        if (link_reset) begin m_rcv = 0; m_cnt = 0; end
        else if (!m_rcv) begin
            if (newpkt) begin m_rcv = 1; m_cnt = 0; end
        end else if (rollback) begin m_rcv = 0; m_cnt = 0; end
        else if (acked) begin m_rcv = 0; m_cnt = 0; m_have = 0; end
        else if (newpkt) m_cnt = 0;
        else if (put && m_have && m_cnt < MaxB + 2) m_cnt++;
    endtask

    task automatic tick();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        rst = 0; link_reset = 0; newpkt = 0; put = 0; acked = 0; rollback = 0;
        sw_if.av_push_i = 0; sw_if.rx_pop_i = 0;
    endtask

    task automatic push_av(input int b);
        sw_if.av_push_i = 1; sw_if.av_buf_i = 3'(b);
        tick();
        idle();
    endtask

    task automatic pop_rx();
        sw_if.rx_pop_i = 1;
        tick();
        idle();
    endtask

    // end_mode: 0 ack, 1 rollback, 2 link reset
    task automatic run_pkt(input int ep, input int n, input int end_mode);
        current = 4'(ep);
        newpkt = 1; tick(); idle();
        for (int i = 0; i < n; i++) begin
            put = 1; addr = 5'(i); data = 8'($urandom);
            tick();
        end
        idle();
        if (end_mode == 0) acked = 1;
        else if (end_mode == 1) rollback = 1;
        else link_reset = 1;
        tick(); idle();
        tick();
    endtask

    initial begin
        idle();
        rst = 1; rx_enable = 4'b0000; current = 0; setup = 0; addr = 0; data = 0;
        sw_if.av_buf_i = 0;
        repeat (2) @(posedge clk);
        model_step(); #1;
        tick();
        check("rst_full", full, 4'hF);
        check("rst_rx_valid", sw_if.rx_valid_o, 0);
        idle();

        // Prefetch latency and first record.
        rx_enable = 4'b0001;
        push_av(3);
        check("full_1cyc", full, 4'hF);
        tick();
        check("full_2cyc", full, 4'b1110);
        run_pkt(0, 10, 0);
        check("rec1_valid", sw_if.rx_valid_o, 1);
        check("rec1_buf", sw_if.rx_buf_o, 3);
        check("rec1_size", sw_if.rx_size_o, 8);
        pop_rx();

        // Rollback keeps the buffer; oversize packet saturates.
        push_av(5); tick();
        run_pkt(0, 5, 1);
        run_pkt(0, 34, 0);
        check("rec2_buf", sw_if.rx_buf_o, 5);
        check("rec2_size", sw_if.rx_size_o, 32);
        pop_rx();

        // Receive FIFO fill, release, and available-FIFO overflow.
        rx_enable = 4'hF;
        for (int k = 0; k < 4; k++) begin
            push_av(k == 3 ? 6 : k + 1); tick();
            run_pkt(k, 3 + k, 0);
        end
        push_av(7); tick();
        check("rxfull_depth", sw_if.rx_depth_o, 4);
        check("rxfull_flags", full, 4'hF);
        pop_rx();
        check("rxpop_flags", full, 4'h0);
        for (int k = 0; k < 4; k++) push_av(k);
        check("av_full", sw_if.av_full_o, 1);
        push_av(4);
        check("av_ovf_pulse", sw_if.av_overflow_o, 1);
        tick();
        check("av_ovf_clear", sw_if.av_overflow_o, 0);

        // Link reset drops the packet; the held buffer is reused.
        run_pkt(1, 3, 2);
        acked = 1; tick(); idle();
        check("lr_depth", sw_if.rx_depth_o, 3);
        run_pkt(2, 4, 0);
        repeat (3) pop_rx();
        check("lr_buf", sw_if.rx_buf_o, 7);
        check("lr_size", sw_if.rx_size_o, 2);
        pop_rx();

`ifdef USB_OUT_SETUP_RSV_EN
        for (int k = 0; k < 3; k++) run_pkt(k + 1, 4, 0);
        rx_enable = 4'b1110; current = 1; setup = 4'b0000; tick();
        check("rsv_out_full", full[1], 1);
        current = 0; setup = 4'b0001; tick();
        check("rsv_setup_ok", full[0], 0);
        run_pkt(0, 10, 0);
        repeat (3) pop_rx();
        check("rsv_setup_rec", sw_if.rx_setup_o, 1);
        check("rsv_setup_size", sw_if.rx_size_o, 8);
        pop_rx();
        setup = 0;
`endif

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            idle();
            rst        = ($urandom_range(999) == 0);
            link_reset = ($urandom_range(99) == 0);
            newpkt     = ($urandom_range(19) == 0);
            put        = 1'($urandom_range(1));
            addr       = 5'($urandom);
            data       = 8'($urandom);
            acked      = ($urandom_range(24) == 0);
            rollback   = ($urandom_range(49) == 0);
            sw_if.av_push_i = ($urandom_range(7) == 0);
            sw_if.av_buf_i  = 3'($urandom);
            sw_if.rx_pop_i  = ($urandom_range(5) == 0);
            if ($urandom_range(49) == 0) rx_enable = 4'($urandom);
            if ($urandom_range(19) == 0) setup = 4'($urandom);
            if (newpkt) current = 4'($urandom_range(4));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/usb_fs_out_buf_ctrl.md
Name: usb_fs_out_buf_ctrl

Overview:
- Buffer and receive-queue controller placed between the full-speed OUT packet engine and the packet SRAM / software register interface.
- Takes free buffer IDs from software through an available FIFO and prefetches one buffer for incoming OUT/SETUP data.
- Drives the per-endpoint full flags back to the packet engine, steers data bytes into the held buffer, and on ACK queues a completion record {buffer, endpoint, setup, size} into a receive FIFO for software.
- On rollback (NAK or bad packet) the held buffer is kept for reuse.

Parameters:
NumOutEps, 4, number of OUT endpoints (1..16)
NumBufs, 8, number of packet buffers in SRAM
MaxOutPktSizeByte, 32, bytes per buffer
PktW, $clog2(MaxOutPktSizeByte), byte address width inside a buffer
BufIdW, $clog2(NumBufs), buffer ID width
AvDepth, 4, available-buffer FIFO depth
RxDepth, 4, receive FIFO depth

Ports:
clk_48mhz_i  in  1  clock
rst_i  in  1  reset, synchronous, active-high
link_reset_i  in  1  USB bus reset
rx_enable_i  in  NumOutEps  per-endpoint receive enable (software)
out_ep_current_i  in  4  endpoint of the current transfer (from packet engine)
out_ep_newpkt_i  in  1  token accepted, transfer starting
out_ep_data_put_i  in  1  data byte valid
out_ep_put_addr_i  in  PktW  byte address
out_ep_data_i  in  8  data byte
out_ep_acked_i  in  1  packet ACKed
out_ep_rollback_i  in  1  packet discarded
out_ep_setup_i  in  NumOutEps  per-endpoint setup flag
out_ep_full_o  out  NumOutEps  endpoint cannot accept data
buf_we_o  out  1  SRAM write strobe
buf_waddr_o  out  BufIdW+PktW  SRAM write address {buf, addr}
buf_wdata_o  out  8  SRAM write data
av_push_i  in  1  software pushes a free buffer
av_buf_i  in  BufIdW  pushed buffer ID
av_full_o  out  1  available FIFO full
av_overflow_o  out  1  one-cycle pulse: push dropped
rx_pop_i  in  1  software pops a completion record
rx_valid_o  out  1  receive FIFO non-empty
rx_buf_o  out  BufIdW  head record buffer
rx_ep_o  out  4  head record endpoint
rx_setup_o  out  1  head record was SETUP
rx_size_o  out  PktW+1  head record payload bytes (0..MaxOutPktSizeByte)
rx_depth_o  out  $clog2(RxDepth+1)  receive FIFO occupancy

Behaviour:
- Reset (rst_i=1, sampled on the clock edge):
  - Both FIFOs empty; have_buf=0; state StIdle; byte_cnt=0.
  - Outputs: out_ep_full_o all 1, buf_we_o=0, av_full_o=0, av_overflow_o=0, rx_valid_o=0, rx_depth_o=0.
  - Record fields are 0 when the FIFO is empty.
- Both FIFOs are registered: a pushed entry becomes visible the next cycle.
- Prefetch:
  - When state==StIdle, have_buf==0 and the available FIFO is non-empty: pop it into cur_buf and set have_buf=1 on the next edge.
  - out_ep_full_o therefore deasserts 2 cycles after av_push_i into an empty controller.
- Full flag, combinational: out_ep_full_o[e] = !have_buf | !rx_enable_i[e] | (rx_depth_o==RxDepth).
- States: StIdle and StRcv.
  - StIdle -> StRcv on out_ep_newpkt_i; byte_cnt cleared.
  - In StRcv, out_ep_newpkt_i again restarts: byte_cnt cleared, buffer kept.
  - StRcv -> StIdle on out_ep_acked_i:
    - Pushes {cur_buf, out_ep_current_i, out_ep_setup_i[ep], size} into the receive FIFO.
    - have_buf cleared; rx_valid_o rises next cycle.
  - StRcv -> StIdle on out_ep_rollback_i: byte_cnt cleared, have_buf unchanged.
  - acked and rollback together: rollback wins.
- Byte counting:
  - byte_cnt has width PktW+2 and increments on each out_ep_data_put_i in StRcv with have_buf=1.
  - It saturates at MaxOutPktSizeByte+2.
  - Payload size = byte_cnt-2 (CRC16 stripped), floored at 0.
- SRAM write, combinational passthrough:
  - buf_we_o = data_put & StRcv & have_buf & byte_cnt<MaxOutPktSizeByte.
  - buf_waddr_o = {cur_buf, out_ep_put_addr_i}; buf_wdata_o = out_ep_data_i.
- Available FIFO push when full: entry dropped, av_overflow_o pulses 1 cycle.
- rx_pop_i when empty: ignored.
- Simultaneous pop and push on either FIFO: both take effect, depth unchanged.
- link_reset_i:
  - Forces StIdle and byte_cnt=0.
  - FIFO contents and the held buffer are retained.
  - A packet in progress is dropped without queuing.
- A stall response never asserts acked, so nothing is queued.

Optional Feature:
- Macro: USB_OUT_SETUP_RSV_EN.
- When defined:
  - SETUP transfers ignore rx_enable_i gating.
  - One receive FIFO slot is reserved for SETUP: non-SETUP endpoints see full when rx_depth_o >= RxDepth-1; SETUP needs rx_depth_o < RxDepth.
  - The SETUP flag used for gating is out_ep_setup_i[out_ep_current_i].
- When undefined: uniform gating exactly as in Behaviour.

Decomposition:
- Shared package usb_out_ctrl_pkg holds:
  - state enum {StIdle, StRcv};
  - the rx record packed struct {buf, ep, setup, size};
  - constant CrcBytes=2.
- Sub-module usb_fs_sync_fifo (parameterised width/depth, registered, with depth output), instantiated twice: available FIFO and receive FIFO.

Test Plan:
- Reset, then push buffer 3 -> out_ep_full_o goes 4'b1111 -> 4'b1110 (only ep0 enabled) 2 cycles later.
- OUT to ep0 with 10 data_puts (8 payload + 2 CRC), then acked -> SRAM writes at addresses {3,0..9}; record buf=3, ep=0, setup=0, size=8.
- Rollback after 5 bytes, then a fresh packet of 34 bytes acked -> same buffer reused; writes stop after 32 bytes; size=32.
- Fill the receive FIFO with 4 records -> all full flags 1; one rx_pop_i -> flags clear the next cycle; 5th av push with 4 queued -> av_overflow_o pulse.
- link_reset_i mid-packet -> no record queued; held buffer reused by the next transfer.
- With USB_OUT_SETUP_RSV_EN, 3 records queued -> OUT gets full=1; SETUP to disabled ep0 accepted with setup=1.
